// File: rtl/conv_pkg.sv
// Shared types and constants for the 1x1 pointwise-convolution MAC stage.
package conv_pkg;

    typedef enum logic [1:0] {
        ST_FILL   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RUN    = 2'd2
    } conv_state_e;

    localparam int SETTLE_CYCLES = 2;
    localparam int SETTLE_W      = $clog2(SETTLE_CYCLES + 1);

    function automatic logic signed [63:0] sat_max(input int dw);
        return (64'sd1 <<< (dw - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] sat_min(input int dw);
        return -(64'sd1 <<< (dw - 1));
    endfunction

endpackage

// File: rtl/conv_1x1_mul_q.sv
// Registered signed fixed-point multiply; the product is floor-shifted by FRAC_BITS
// and wrapped to OUT_W bits.
module conv_1x1_mul_q #(
    parameter int DATA_WIDTH = 32,
    parameter int FRAC_BITS  = 16,
    parameter int OUT_W      = 35
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         vld_in,
    input  logic signed [DATA_WIDTH-1:0] a,
    input  logic signed [DATA_WIDTH-1:0] b,
    output logic                         vld_out,
    output logic signed [OUT_W-1:0]      prod
);

    localparam int FULL_W = 2 * DATA_WIDTH;

    logic signed [FULL_W-1:0] full_prod;
    logic signed [OUT_W-1:0]  prod_d, prod_q;
    logic                     vld_d, vld_q;

    always_comb begin
        full_prod = FULL_W'(a) * FULL_W'(b);
        prod_d    = OUT_W'(full_prod >>> FRAC_BITS);
        vld_d     = vld_in;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prod_q <= '0;
            vld_q  <= 1'b0;
        end else begin
            prod_q <= prod_d;
            vld_q  <= vld_d;
        end
    end

    assign prod    = prod_q;
    assign vld_out = vld_q;

endmodule

// File: rtl/conv_1x1_mac.sv
// Pointwise-convolution MAC: counts buffer fills, pops one weight per accepted pixel
// and emits one saturated sum per WEIGHT_NUM pixels.
//
// state  | meaning
// FILL   | counting weights written into the upstream buffer
// SETTLE | waiting for the buffer's input register and FIFO write
// RUN    | ready; each accepted pixel pops one weight
module conv_1x1_mac
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int FRAC_BITS   = 16,
    parameter int WEIGHT_NUM  = 4,
    parameter int COUNT_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wt_valid_in,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] in,
    input  logic [DATA_WIDTH-1:0] weight_in,
    output logic                  load_weights,
    output logic                  ready,
    output logic [DATA_WIDTH-1:0] out,
    output logic                  valid_out,
    output logic                  err
);

    localparam int ACC_W = DATA_WIDTH + COUNT_WIDTH + 1;
    localparam logic [COUNT_WIDTH-1:0] CNT_LAST    = COUNT_WIDTH'(WEIGHT_NUM - 1);
    localparam logic [SETTLE_W-1:0]    SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES - 1);
    localparam logic signed [ACC_W-1:0] ACC_MAX    = ACC_W'(sat_max(DATA_WIDTH));
    localparam logic signed [ACC_W-1:0] ACC_MIN    = ACC_W'(sat_min(DATA_WIDTH));

    conv_state_e              state_d, state_q;
    logic [COUNT_WIDTH-1:0]   fill_cnt_d, fill_cnt_q;
    logic [COUNT_WIDTH-1:0]   elem_cnt_d, elem_cnt_q;
    logic [SETTLE_W-1:0]      settle_cnt_d, settle_cnt_q;
    logic                     ready_d, ready_q;
    logic                     err_d, err_q;
    logic [DATA_WIDTH-1:0]    pix_d, pix_q;
    logic                     pix_vld_d, pix_vld_q;
    logic                     last1_d, last1_q;
    logic                     last2_d, last2_q;
    logic signed [ACC_W-1:0]  acc_d, acc_q;
    logic signed [ACC_W-1:0]  sum;
    logic [DATA_WIDTH-1:0]    out_d, out_q;
    logic                     valid_out_d, valid_out_q;
    logic                     accept_last;
    logic signed [ACC_W-1:0]  prod;
    logic                     prod_vld;

    assign load_weights = valid_in & ready_q;
    assign accept_last  = load_weights && (elem_cnt_q == CNT_LAST);

    conv_1x1_mul_q #(
        .DATA_WIDTH(DATA_WIDTH),
        .FRAC_BITS (FRAC_BITS),
        .OUT_W     (ACC_W)
    ) u_mul (
        .clk    (clk),
        .reset  (reset),
        .vld_in (pix_vld_q),
        .a      (pix_q),
        .b      (weight_in),
        .vld_out(prod_vld),
        .prod   (prod)
    );

    always_comb begin
        state_d      = state_q;
        fill_cnt_d   = fill_cnt_q;
        elem_cnt_d   = elem_cnt_q;
        settle_cnt_d = settle_cnt_q;
        err_d        = err_q | (wt_valid_in && (state_q != ST_FILL));

        case (state_q)
            ST_FILL: begin
                if (wt_valid_in) begin
                    if (fill_cnt_q == CNT_LAST) begin
                        fill_cnt_d   = '0;
                        settle_cnt_d = SETTLE_LOAD;
                        state_d      = ST_SETTLE;
                    end else begin
                        fill_cnt_d = fill_cnt_q + COUNT_WIDTH'(1);
                    end
                end
            end
            ST_SETTLE: begin
                if (settle_cnt_q == '0) state_d = ST_RUN;
                else                    settle_cnt_d = settle_cnt_q - SETTLE_W'(1);
            end
            ST_RUN: begin
                if (load_weights) begin
                    if (accept_last) begin
                        elem_cnt_d = '0;
                        state_d    = ST_FILL;
                    end else begin
                        elem_cnt_d = elem_cnt_q + COUNT_WIDTH'(1);
                    end
                end
            end
            default: state_d = ST_FILL;
        endcase

        ready_d = (state_d == ST_RUN);
    end

    // Pipeline: pixel register, multiplier, then accumulate; the last-element flag
    // rides alongside so draining continues after the FSM has left RUN.
    always_comb begin
        pix_vld_d   = load_weights;
        pix_d       = load_weights ? in : pix_q;
        last1_d     = accept_last;
        last2_d     = last1_q;
        sum         = acc_q + prod;
        acc_d       = acc_q;
        out_d       = out_q;
        valid_out_d = 1'b0;

        if (prod_vld) begin
            if (last2_q) begin
                acc_d       = '0;
                valid_out_d = 1'b1;
                if (sum > ACC_MAX)      out_d = ACC_MAX[DATA_WIDTH-1:0];
                else if (sum < ACC_MIN) out_d = ACC_MIN[DATA_WIDTH-1:0];
                else                    out_d = sum[DATA_WIDTH-1:0];
            end else begin
                acc_d = sum;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_FILL;
            fill_cnt_q   <= '0;
            elem_cnt_q   <= '0;
            settle_cnt_q <= '0;
            ready_q      <= 1'b0;
            err_q        <= 1'b0;
            pix_q        <= '0;
            pix_vld_q    <= 1'b0;
            last1_q      <= 1'b0;
            last2_q      <= 1'b0;
            acc_q        <= '0;
            out_q        <= '0;
            valid_out_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            fill_cnt_q   <= fill_cnt_d;
            elem_cnt_q   <= elem_cnt_d;
            settle_cnt_q <= settle_cnt_d;
            ready_q      <= ready_d;
            err_q        <= err_d;
            pix_q        <= pix_d;
            pix_vld_q    <= pix_vld_d;
            last1_q      <= last1_d;
            last2_q      <= last2_d;
            acc_q        <= acc_d;
            out_q        <= out_d;
            valid_out_q  <= valid_out_d;
        end
    end

    assign ready     = ready_q;
    assign err       = err_q;
    assign out       = out_q;
    assign valid_out = valid_out_q;

endmodule

// File: tb/tb_conv_1x1_mac.sv
// Directed bench for conv_1x1_mac with a small model of the upstream weight FIFO.
module tb_conv_1x1_mac;

    logic        clk = 1'b0;
    logic        reset;
    logic        wt_valid_in;
    logic        valid_in;
    logic [31:0] pix_in;
    logic [31:0] weight_in = '0;
    logic        load_weights;
    logic        ready;
    logic [31:0] out;
    logic        valid_out;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    logic        buf_push;
    logic [31:0] wt_data;
    logic [31:0] wq[$];
    logic        lw_seen   = 1'b0;
    logic        push_seen = 1'b0;
    logic [31:0] push_val  = '0;

    int          cyc = 0;
    int          lw_cnt = 0;
    int          vo_cnt = 0;
    int          last_lw_cyc = 0;
    int          vo_cyc = 0;
    logic [31:0] vo_val = '0;

    always #5 clk = ~clk;

    conv_1x1_mac dut (
        .clk         (clk),
        .reset       (reset),
        .wt_valid_in (wt_valid_in),
        .valid_in    (valid_in),
        .in          (pix_in),
        .weight_in   (weight_in),
        .load_weights(load_weights),
        .ready       (ready),
        .out         (out),
        .valid_out   (valid_out),
        .err         (err)
    );

    always @(negedge clk) begin
        lw_seen   = load_weights;
        push_seen = buf_push;
        push_val  = wt_data;
        if (load_weights) begin
            lw_cnt++;
            last_lw_cyc = cyc;
        end
        if (valid_out) begin
            vo_cnt++;
            vo_cyc = cyc;
            vo_val = out;
        end
        cyc++;
    end

    // Weight FIFO: popped data appears the cycle after load_weights.
    always @(posedge clk) begin
        if (reset) begin
            wq.delete();
        end else begin
            if (push_seen) wq.push_back(push_val);
            if (lw_seen) weight_in <= (wq.size() > 0) ? wq.pop_front() : 32'h0;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_wts(input string tag, input logic [31:0] w);
        int lw0;
        lw0 = lw_cnt;
        for (int i = 0; i < 4; i++) begin
            wt_valid_in = 1'b1;
            buf_push    = 1'b1;
            wt_data     = w;
            check_val({tag, "_fill_ready"}, {31'b0, ready}, 32'd0);
            tick();
        end
        wt_valid_in = 1'b0;
        buf_push    = 1'b0;
        check_val({tag, "_settle0_ready"}, {31'b0, ready}, 32'd0);
        tick();
        check_val({tag, "_settle1_ready"}, {31'b0, ready}, 32'd0);
        tick();
        check_val({tag, "_run_ready"}, {31'b0, ready}, 32'd1);
        check_val({tag, "_no_early_pop"}, 32'(lw_cnt - lw0), 32'd0);
    endtask

    task automatic send_pix(input string tag, input logic [31:0] p);
        bit done;
        done     = 1'b0;
        valid_in = 1'b1;
        pix_in   = p;
        for (int k = 0; k < 40; k++) begin
            if (ready) begin
                tick();
                done = 1'b1;
                break;
            end
            tick();
        end
        valid_in = 1'b0;
        if (!done) check_val({tag, "_accept_timeout"}, {31'b0, done}, 32'd1);
    endtask

    task automatic run_sample(input string tag, input logic [31:0] w,
                              input logic [31:0] p0, input logic [31:0] p1,
                              input logic [31:0] p2, input logic [31:0] p3,
                              input bit gaps, input bit pre_valid, input bit inj_err,
                              input logic [31:0] exp);
        logic [31:0] p[4];
        int lw0, vo0;
        p[0] = p0; p[1] = p1; p[2] = p2; p[3] = p3;
        lw0 = lw_cnt;
        vo0 = vo_cnt;
        if (pre_valid) begin
            valid_in = 1'b1;
            pix_in   = p0;
        end
        load_wts(tag, w);
        for (int i = 0; i < 4; i++) begin
            send_pix(tag, p[i]);
            if (inj_err && i == 1) begin
                wt_valid_in = 1'b1;
                tick();
                wt_valid_in = 1'b0;
                check_val({tag, "_err_set"}, {31'b0, err}, 32'd1);
            end
            if (gaps && i < 3) repeat (i + 1) tick();
        end
        for (int k = 0; k < 10 && vo_cnt == vo0; k++) tick();
        repeat (3) tick();
        check_val({tag, "_pulses"}, 32'(vo_cnt - vo0), 32'd1);
        check_val({tag, "_value"}, vo_val, exp);
        check_val({tag, "_out_hold"}, out, exp);
        check_val({tag, "_latency"}, 32'(vo_cyc - last_lw_cyc), 32'd3);
        check_val({tag, "_pops"}, 32'(lw_cnt - lw0), 32'd4);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lw0, vo0;
        reset       = 1'b1;
        wt_valid_in = 1'b0;
        valid_in    = 1'b0;
        pix_in      = '0;
        buf_push    = 1'b0;
        wt_data     = '0;
        tick();
        tick();
        check_val("rst_out", out, 32'd0);
        check_val("rst_valid_out", {31'b0, valid_out}, 32'd0);
        check_val("rst_ready", {31'b0, ready}, 32'd0);
        check_val("rst_load", {31'b0, load_weights}, 32'd0);
        check_val("rst_err", {31'b0, err}, 32'd0);
        reset = 1'b0;

        // Pixels offered while still in FILL are dropped.
        lw0 = lw_cnt;
        valid_in = 1'b1;
        pix_in   = 32'h0001_0000;
        repeat (3) tick();
        check_val("fill_drop_ready", {31'b0, ready}, 32'd0);
        check_val("fill_drop_pops", 32'(lw_cnt - lw0), 32'd0);
        check_val("fill_drop_err", {31'b0, err}, 32'd0);
        valid_in = 1'b0;

        run_sample("basic", 32'h0001_0000, 32'h0001_0000, 32'h0002_0000,
                   32'h0003_0000, 32'h0004_0000, 1'b0, 1'b0, 1'b0, 32'h000A_0000);
        run_sample("neg_trunc", 32'hFFFF_8000, 32'h0000_0001, 32'h0000_0001,
                   32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFC);
        run_sample("sat_pos", 32'h7FFF_0000, 32'h0002_0000, 32'h0002_0000,
                   32'h0002_0000, 32'h0002_0000, 1'b0, 1'b0, 1'b0, 32'h7FFF_FFFF);
        run_sample("sat_neg", 32'h8001_0000, 32'h0002_0000, 32'h0002_0000,
                   32'h0002_0000, 32'h0002_0000, 1'b0, 1'b0, 1'b0, 32'h8000_0000);
        run_sample("gaps", 32'h0001_0000, 32'h0001_0000, 32'h0002_0000,
                   32'h0003_0000, 32'h0004_0000, 1'b1, 1'b1, 1'b0, 32'h000A_0000);
        run_sample("seq_a", 32'h0002_0000, 32'h0001_0000, 32'h0001_0000,
                   32'h0001_0000, 32'h0001_0000, 1'b0, 1'b0, 1'b0, 32'h0008_0000);
        run_sample("seq_b", 32'h0000_8000, 32'h0004_0000, 32'hFFFE_0000,
                   32'h0006_0000, 32'h0000_8000, 1'b0, 1'b0, 1'b0, 32'h0004_4000);
        run_sample("proto_err", 32'h0001_0000, 32'h0001_0000, 32'h0002_0000,
                   32'h0003_0000, 32'h0004_0000, 1'b0, 1'b0, 1'b1, 32'h000A_0000);
        run_sample("after_err", 32'h0002_0000, 32'h0001_0000, 32'h0001_0000,
                   32'h0001_0000, 32'h0001_0000, 1'b0, 1'b0, 1'b0, 32'h0008_0000);
        check_val("err_sticky", {31'b0, err}, 32'd1);

        // Reset after two of four elements.
        load_wts("mid_rst", 32'h0001_0000);
        send_pix("mid_rst", 32'h0001_0000);
        send_pix("mid_rst", 32'h0002_0000);
        vo0   = vo_cnt;
        reset = 1'b1;
        tick();
        check_val("mid_rst_out", out, 32'd0);
        check_val("mid_rst_valid_out", {31'b0, valid_out}, 32'd0);
        check_val("mid_rst_ready", {31'b0, ready}, 32'd0);
        check_val("mid_rst_load", {31'b0, load_weights}, 32'd0);
        check_val("mid_rst_err", {31'b0, err}, 32'd0);
        reset = 1'b0;
        repeat (6) tick();
        check_val("mid_rst_no_pulse", 32'(vo_cnt - vo0), 32'd0);
        run_sample("post_rst", 32'h0001_0000, 32'h0001_0000, 32'h0002_0000,
                   32'h0003_0000, 32'h0004_0000, 1'b0, 1'b0, 1'b0, 32'h000A_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
